smooth_out_collector: RTL and testbench

- Sits directly downstream of the 3x3 smoothing filter and consumes its unqualified 10-bit result stream.
- Re-derives a valid qualifier by delaying the filter's input valid by the filter's pipeline latency, and tracks raster position.
- Drops border pixels whose 3x3 window is incomplete, then buffers kept pixels in a first-word-fall-through FIFO with a valid/ready handshake toward the frame-store write port.

---
 rtl/smooth_out_collector_if.sv | 24 ++
 rtl/smooth_out_collector.sv | 178 +++++++++++++++++
 tb/tb_smooth_out_collector.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/smooth_out_collector_if.sv
// Handshake bundle between the smoothing filter, the collector and the frame-store write port.
// master drives the filter-side stream and iready; slave is the collector.
interface smooth_out_collector_if #(
  parameter int DATA_W = 10
);
  logic              sof;
  logic              idata_valid;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic              iready;
  logic              frame_done;
  logic              overflow;

  modport master (
    output sof, idata_valid, data_in, iready,
    input  odata, ovalid, frame_done, overflow
  );

  modport slave (
    input  sof, idata_valid, data_in, iready,
    output odata, ovalid, frame_done, overflow
  );
endinterface

// File: rtl/smooth_out_collector.sv
// Qualifies the 3x3 smoothing filter's result stream, drops incomplete-window border pixels and
// buffers kept pixels in a registered FWFT FIFO. Define SMOOTH_BORDER_PASS_EN to emit borders as 0.
module smooth_out_collector #(
  parameter int DATA_W       = 10,
  parameter int LATENCY      = 3,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  smooth_out_collector_if.slave  bus
);

  localparam int CW = $clog2(LINE_WIDTH + 1);
  localparam int RW = $clog2(FRAME_HEIGHT + 1);
  localparam int FW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [LATENCY-1:0]  pipe_q, pipe_d;
  logic                start, keep, done;
  logic                interior;

  // Counter position is the sample being accepted; its window centre is one column/row behind.
  assign interior = (col_q >= CW'(2)) && (row_q >= RW'(2));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    start   = 1'b0;
    keep    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sof) start = 1'b1;
      end
      ACTIVE: begin
        if (bus.sof) begin
          start = 1'b1;
        end else if (bus.idata_valid) begin
`ifdef SMOOTH_BORDER_PASS_EN
          keep = 1'b1;
`else
          keep = interior;
`endif
          if (col_q == CW'(LINE_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == RW'(FRAME_HEIGHT - 1)) begin
              row_d   = '0;
              fcnt_d  = '0;
              state_d = FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (bus.sof) begin
          start = 1'b1;
        end else if (fcnt_q == FW'(LATENCY - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = ACTIVE;
      col_d   = '0;
      row_d   = '0;
      fcnt_d  = '0;
    end
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = keep;
    for (int unsigned i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (start) pipe_d = '0;
  end

  logic [DATA_W-1:0] wdata;
`ifdef SMOOTH_BORDER_PASS_EN
  logic [LATENCY-1:0] brd_q, brd_d;

  always_comb begin
    brd_d    = '0;
    brd_d[0] = keep & ~interior;
    for (int unsigned i = 1; i < LATENCY; i++) brd_d[i] = brd_q[i-1];
    if (start) brd_d = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) brd_q <= '0;
    else        brd_q <= brd_d;
  end

  assign wdata = brd_q[LATENCY-1] ? '0 : bus.data_in;
`else
  assign wdata = bus.data_in;
`endif

  // Output FIFO: pointers carry a wrap bit so full and empty are distinguishable.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d, used;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, wr_req, wr_en, rd_en, drop;

  assign used   = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_req = pipe_q[LATENCY-1] & ~start;
  assign rd_en  = ~empty & bus.iready;
  assign wr_en  = wr_req & (~full | rd_en);
  assign drop   = wr_req & full & ~rd_en;

  // odata_q always mirrors mem[rptr]; refresh it from the next slot or the bypassed write.
  always_comb begin
    odata_d = odata_q;
    if (rd_en) begin
      if (used > (AW+1)'(1))  odata_d = mem[rptr_q[AW-1:0] + AW'(1)];
      else if (wr_en)         odata_d = wdata;
    end else if (empty && wr_en) begin
      odata_d = wdata;
    end
    wptr_d     = wptr_q + {{AW{1'b0}}, wr_en};
    rptr_d     = rptr_q + {{AW{1'b0}}, rd_en};
    overflow_d = start ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      fcnt_q     <= '0;
      pipe_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      odata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fcnt_q     <= fcnt_d;
      pipe_q     <= pipe_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      odata_q    <= odata_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.odata      = odata_q;
  assign bus.ovalid     = ~empty;
  assign bus.frame_done = done;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_smooth_out_collector.sv
// Randomised bench for smooth_out_collector on a 4x4 frame, LATENCY 3, two-entry FIFO,
// checked against a queue-based model of the keep rule, pipeline delay and FIFO.
module tb_smooth_out_collector;
  localparam int DW  = 10;
  localparam int LAT = 3;
  localparam int LW  = 4;
  localparam int FH  = 4;
  localparam int FD  = 2;
`ifdef SMOOTH_BORDER_PASS_EN
  localparam int NWORDS = LW * FH;
`else
  localparam int NWORDS = (LW - 2) * (FH - 2);
`endif

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  smooth_out_collector_if #(.DATA_W(DW)) bus ();

  smooth_out_collector #(
    .DATA_W(DW), .LATENCY(LAT), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model state
  bit      m_active  = 1'b0;
  int      m_idx     = 0;
  int      m_done_at = -1;
  bit      m_ovf     = 1'b0;
  int      pend[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] got_out[$];
  int      exp_fd[$];
  int      got_fd[$];

  task automatic clear_obs();
    got_out.delete(); exp_out.delete(); got_fd.delete(); exp_fd.delete();
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_idx = 0; m_done_at = -1; m_ovf = 1'b0;
    pend.delete(); mq.delete();
  endtask

  // One clock cycle: drive at the falling edge, observe 1ns later, advance the model.
  task automatic tick(input logic s, input logic v, input logic [DW-1:0] d, input logic r);
    bit full, rd, brd;
    int e, col, row;
    bus.sof = s; bus.idata_valid = v; bus.data_in = d; bus.iready = r;
    #1;
    if (bus.ovalid && r) got_out.push_back(bus.odata);
    if (bus.frame_done) got_fd.push_back(cyc);
    full = (mq.size() >= FD);
    rd   = (mq.size() > 0) && r;
    if (rd) exp_out.push_back(mq.pop_front());
    if (s) begin
      if (m_active || m_done_at >= cyc) begin pend.delete(); m_done_at = -1; end
      m_active = 1'b1; m_idx = 0; m_ovf = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0] / 2 == cyc) begin
        e = pend.pop_front();
        if (!full || rd) mq.push_back((e % 2 == 1) ? '0 : d);
        else m_ovf = 1'b1;
      end
      if (m_done_at == cyc) exp_fd.push_back(cyc);
      if (m_active && v) begin
        col = m_idx % LW; row = m_idx / LW;
        brd = (col < 2) || (row < 2);
`ifdef SMOOTH_BORDER_PASS_EN
        pend.push_back((cyc + LAT) * 2 + int'(brd));
`else
        if (!brd) pend.push_back((cyc + LAT) * 2);
`endif
        m_idx++;
        if (m_idx == LW * FH) begin m_active = 1'b0; m_done_at = cyc + LAT; end
      end
    end
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    bus.sof = 1'b0; bus.idata_valid = 1'b0; bus.data_in = '0; bus.iready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    tests++; if (bus.ovalid !== 1'b0) begin fails++; $display("FAIL reset_ovalid: got %b expected 0", bus.ovalid); end
    tests++; if (bus.odata !== '0) begin fails++; $display("FAIL reset_odata: got %0d expected 0", bus.odata); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    @(negedge clk_in);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    int s15;
    clear_obs();
    tick(1'b1, 1'b0, '0, 1'b1);
    s15 = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) s15 = cyc;
      tick(1'b0, 1'b1, DW'(cyc), 1'b1);
    end
    repeat (8) tick(1'b0, 1'b0, DW'(cyc), 1'b1);
    tests++; if (got_out.size() != NWORDS) begin fails++; $display("FAIL b2b_count: got %0d words expected %0d", got_out.size(), NWORDS); end
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      tests++; if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL b2b_word%0d: got %0d expected %0d", i, got_out[i], exp_out[i]); end
    end
    tests++; if (got_fd.size() != 1) begin fails++; $display("FAIL b2b_fd_count: got %0d expected 1", got_fd.size()); end
    if (got_fd.size() > 0) begin
      tests++; if (got_fd[0] != s15 + LAT) begin fails++; $display("FAIL b2b_fd_cycle: got %0d expected %0d", got_fd[0], s15 + LAT); end
    end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_valid_gaps();
    clear_obs();
    tick(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 32; i++) tick(1'b0, (i % 2 == 0), DW'($urandom), 1'b1);
    repeat (8) tick(1'b0, 1'b0, DW'($urandom), 1'b1);
    tests++; if (got_out.size() != exp_out.size()) begin fails++; $display("FAIL gaps_count: got %0d expected %0d", got_out.size(), exp_out.size()); end
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      tests++; if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL gaps_word%0d: got %0d expected %0d", i, got_out[i], exp_out[i]); end
    end
    tests++; if (got_fd.size() != exp_fd.size() || got_fd.size() != 1) begin fails++; $display("FAIL gaps_fd: got %0d pulses expected 1", got_fd.size()); end
  endtask

  task automatic test_overflow();
    int c10;
    clear_obs();
    tick(1'b1, 1'b0, '0, 1'b0);
    c10 = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 10) c10 = cyc;
      tick(1'b0, 1'b1, DW'(cyc), 1'b0);
    end
    repeat (6) tick(1'b0, 1'b0, DW'(cyc), 1'b0);
    #1;
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    tests++; if (bus.ovalid !== 1'b1) begin fails++; $display("FAIL ovf_held: got %b expected 1", bus.ovalid); end
    repeat (6) tick(1'b0, 1'b0, DW'(cyc), 1'b1);
    tests++; if (got_out.size() != FD) begin fails++; $display("FAIL ovf_count: got %0d expected %0d", got_out.size(), FD); end
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      tests++; if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL ovf_word%0d: got %0d expected %0d", i, got_out[i], exp_out[i]); end
    end
`ifndef SMOOTH_BORDER_PASS_EN
    if (got_out.size() == 2) begin
      tests++; if (got_out[0] !== DW'(c10 + LAT) || got_out[1] !== DW'(c10 + 1 + LAT)) begin
        fails++; $display("FAIL ovf_order: got %0d,%0d expected %0d,%0d", got_out[0], got_out[1], c10 + LAT, c10 + 1 + LAT);
      end
    end
`endif
    #1;
    tests++; if (bus.ovalid !== 1'b0) begin fails++; $display("FAIL ovf_drained: got %b expected 0", bus.ovalid); end
  endtask

  task automatic test_abort();
    clear_obs();
    tick(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b1, DW'(cyc), 1'b1);
    #1;
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL abort_ovf_clear: got %b expected 0", bus.overflow); end
    tick(1'b1, 1'b0, DW'(cyc), 1'b1);
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b1, DW'(cyc), 1'b1);
    repeat (8) tick(1'b0, 1'b0, DW'(cyc), 1'b1);
    tests++; if (got_fd.size() != 1) begin fails++; $display("FAIL abort_fd_count: got %0d expected 1", got_fd.size()); end
    tests++; if (got_out.size() != NWORDS) begin fails++; $display("FAIL abort_count: got %0d expected %0d", got_out.size(), NWORDS); end
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      tests++; if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL abort_word%0d: got %0d expected %0d", i, got_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_full_read();
    int s0;
    clear_obs();
    tick(1'b1, 1'b0, '0, 1'b0);
    s0 = cyc;
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b1, DW'(cyc), (cyc >= s0 + 17));
    repeat (8) tick(1'b0, 1'b0, DW'(cyc), (cyc >= s0 + 17));
    tests++; if (bus.overflow !== m_ovf) begin fails++; $display("FAIL fullrd_overflow: got %b expected %b", bus.overflow, m_ovf); end
`ifndef SMOOTH_BORDER_PASS_EN
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL fullrd_nodrop: got %b expected 0", bus.overflow); end
`endif
    tests++; if (got_out.size() != exp_out.size()) begin fails++; $display("FAIL fullrd_count: got %0d expected %0d", got_out.size(), exp_out.size()); end
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      tests++; if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL fullrd_word%0d: got %0d expected %0d", i, got_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b1, DW'(cyc), 1'b0);
    repeat (2) tick(1'b0, 1'b0, DW'(cyc), 1'b0);
    bus.sof = 1'b0; bus.idata_valid = 1'b0; bus.iready = 1'b0;
    #1;
    tests++; if (bus.frame_done !== (m_done_at == cyc)) begin fails++; $display("FAIL rstmid_pre_fd: got %b expected %b", bus.frame_done, (m_done_at == cyc)); end
    tests++; if (bus.ovalid !== (mq.size() > 0)) begin fails++; $display("FAIL rstmid_pre_ovalid: got %b expected %b", bus.ovalid, (mq.size() > 0)); end
    tests++; if (bus.overflow !== m_ovf) begin fails++; $display("FAIL rstmid_pre_ovf: got %b expected %b", bus.overflow, m_ovf); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.ovalid !== 1'b0) begin fails++; $display("FAIL rstmid_ovalid: got %b expected 0", bus.ovalid); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rstmid_overflow: got %b expected 0", bus.overflow); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL rstmid_frame_done: got %b expected 0", bus.frame_done); end
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    cyc++;
    clear_obs();
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b1, DW'(cyc), 1'b1);
    repeat (6) tick(1'b0, 1'b0, DW'(cyc), 1'b1);
    tests++; if (got_out.size() != 0) begin fails++; $display("FAIL rstmid_ignored_words: got %0d expected 0", got_out.size()); end
    tests++; if (got_fd.size() != 0) begin fails++; $display("FAIL rstmid_ignored_fd: got %0d expected 0", got_fd.size()); end
  endtask

  task automatic test_random();
    clear_obs();
    for (int f = 0; f < 8; f++) begin
      tick(1'b1, 1'b0, DW'($urandom), 1'($urandom_range(0, 1)));
      for (int n = 0; n < 200 && (m_active || m_done_at >= cyc); n++) begin
        if ($urandom_range(0, 59) == 0) tick(1'b1, 1'b0, DW'($urandom), 1'($urandom_range(0, 1)));
        else tick(1'b0, ($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 6));
      end
    end
    repeat (10) tick(1'b0, 1'b0, DW'($urandom), 1'b1);
    tests++; if (got_out.size() != exp_out.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got_out.size(), exp_out.size()); end
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
      tests++; if (got_out[i] !== exp_out[i]) begin fails++; $display("FAIL rand_word%0d: got %0d expected %0d", i, got_out[i], exp_out[i]); end
    end
    tests++; if (got_fd.size() != exp_fd.size()) begin fails++; $display("FAIL rand_fd_count: got %0d expected %0d", got_fd.size(), exp_fd.size()); end
    for (int i = 0; i < got_fd.size() && i < exp_fd.size(); i++) begin
      tests++; if (got_fd[i] != exp_fd[i]) begin fails++; $display("FAIL rand_fd%0d: got cycle %0d expected %0d", i, got_fd[i], exp_fd[i]); end
    end
    #1;
    tests++; if (bus.overflow !== m_ovf) begin fails++; $display("FAIL rand_overflow: got %b expected %b", bus.overflow, m_ovf); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_gaps();
    test_overflow();
    test_abort();
    test_full_read();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end
endmodule
